snake_game_ctrl: RTL and testbench
==================================

Name: snake_game_ctrl

Overview:
- Sequencer for the snake display datapath: generates the game tick, arbitrates direction-switch input, and issues one-cycle step requests to the datapath.
- Collects the datapath step acknowledgement with collide/eat flags, then runs the game-over blink sequence and re-initialises the datapath.
- Sits between the board switches and the snake body/display datapath. The datapath owns the body registers; this block owns when they move and in which direction.

Parameters:
- TICK_DIV, 5000000, clock cycles per game tick (10 Hz at 50 MHz); minimum 2.
- DEAD_TICKS, 6, game ticks spent in DEAD (blink phases) before restart.
- SCORE_MAX, 255, saturation value of score.

Ports:
- clock  input  1  system clock, all state on posedge.
- reset  input  1  asynchronous active-low reset.
- switch  input  4  raw direction buttons: 1000 up, 0100 down, 0010 left, 0001 right.
- step_done  input  1  datapath has completed the requested step; collide/eat are valid in this cycle.
- collide  input  1  head hit wall or body (sampled only with step_done).
- eat  input  1  head reached food (sampled only with step_done).
- step  output  1  one-cycle pulse: datapath advances head one cell in direction.
- clear  output  1  one-cycle pulse: datapath reloads initial body.
- direction  output  2  committed heading: 0 up, 1 down, 2 left, 3 right.
- score  output  8  foods eaten this game, saturating.
- blank  output  1  display blank request (blink during DEAD).
- state  output  2  0 INIT, 1 IDLE, 2 RUN (WAIT/STEP), 3 DEAD.

Behaviour:
- Reset (reset=0, async):
  - FSM=INIT, tick counter 0, direction=3, pending=3, score=0.
  - step=0, blank=0, switch synchronizer=0.
  - clear is a Moore output of INIT, so it is 1 in the first cycle after reset release.
- Switch path:
  - 2-FF synchronizer, then decode.
  - Only the four one-hot codes are valid; 0000 and multi-bit codes are ignored.
  - A decoded press reaches pending 2 cycles after the pin changes.
- Arbitration in IDLE/WAIT/STEP: a valid code updates pending unless it is the opposite of the committed direction (up<->down, left<->right).
  - Rejected codes leave pending unchanged.
  - Last accepted code before the step wins.
  - Held buttons re-apply every cycle; this is harmless.
- FSM:
  - INIT: clear=1 for exactly one cycle. Then IDLE.
  - IDLE: wait for an accepted valid code (committed=3, so left is rejected). On acceptance: score<=0, tick counter<=0, go WAIT.
  - WAIT: tick counter increments each cycle. When it reaches TICK_DIV-1: direction<=pending, step=1 in that same cycle, counter<=0, go STEP.
    - The datapath sees step together with the new direction value, because both are registered on the same edge.
  - STEP: tick counter halted, step=0. Wait indefinitely for step_done.
    - step_done & collide: go DEAD; eat is ignored.
    - step_done & ~collide: if eat, score<=min(score+1, SCORE_MAX); go WAIT.
    - step_done outside STEP is ignored.
  - DEAD: tick counter runs as in WAIT. Each tick toggles blank. After DEAD_TICKS ticks: blank<=0, go INIT.
    - score is held through DEAD/INIT/IDLE until the next game start.
    - Switch input is ignored in DEAD.
- step period = TICK_DIV cycles + datapath latency; step never asserts twice without an intervening step_done.
- Reset asserted mid-operation (any state, including STEP awaiting done): immediate return to reset values. A pending step_done is discarded.
- Widths: tick counter is ceil(log2(TICK_DIV)) bits, DEAD counter is 3+ bits; no wrap.

Test Plan:
- Reset release with TICK_DIV=4 -> clear high exactly cycle 1; state 0 then 1; direction=3, score=0, step=0.
- IDLE, switch=0010 (left) then 1000 (up) -> left ignored (stays IDLE). Up accepted 2 cycles after pin change, state=2. step pulses 4 cycles after WAIT entry with direction=0.
- RUN heading up, press 0100 (down) then 0010 (left) inside one tick -> down rejected; next step carries direction=2. With step_done returned 3 cycles later, the following step comes 4 cycles after done.
- Return step_done with eat=1 300 times (score forced near max) -> score increments once per done, saturates at 255. step_done with eat=1 while in WAIT causes no change.
- step_done & collide=1 & eat=1 -> state=3, score unchanged. blank toggles every 4 cycles, 6 times. Then clear pulse, state=1, score retained until the next start, where it resets to 0.
- Assert reset while in STEP awaiting done, release -> all outputs at reset values, clear pulse. A late step_done is ignored, with no score change.

Source files
------------

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl
//   Sequencer for the snake display datapath. It generates the game tick,
//   arbitrates the direction buttons, issues one-cycle step requests, collects
//   the step acknowledgement with its collide/eat flags, runs the game-over
//   blink and re-initialises the datapath.
//
// Ports
//   clock      in   system clock, all state on posedge
//   reset      in   asynchronous active-low reset
//   switch     in   raw buttons: 1000 up, 0100 down, 0010 left, 0001 right
//   step_done  in   datapath finished the step; collide/eat valid this cycle
//   collide    in   head hit wall or body
//   eat        in   head reached food
//   step       out  one-cycle pulse: advance head one cell in direction
//   clear      out  high while in INIT: datapath reloads initial body
//   direction  out  committed heading: 0 up, 1 down, 2 left, 3 right
//   score      out  foods eaten this game, saturating at SCORE_MAX
//   blank      out  display blank request, blinks during DEAD
//   state      out  0 INIT, 1 IDLE, 2 RUN (WAIT/STEP), 3 DEAD
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_INIT | clear datapath for one cycle, restore heading to right
// S_IDLE | wait for an accepted button press to start a game
// S_WAIT | tick timer running; on terminal count commit heading, step
// S_STEP | timer halted, waiting for step_done from the datapath
// S_DEAD | timer running, blank toggles each tick, then back to INIT

module snake_game_ctrl #(
  parameter int TICK_DIV   = 5000000,
  parameter int DEAD_TICKS = 6,
  parameter int SCORE_MAX  = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] switch,
  input  logic       step_done,
  input  logic       collide,
  input  logic       eat,
  output logic       step,
  output logic       clear,
  output logic [1:0] direction,
  output logic [7:0] score,
  output logic       blank,
  output logic [1:0] state
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int DW = ($clog2(DEAD_TICKS) < 3) ? 3 : $clog2(DEAD_TICKS);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_TICKS - 1);
  localparam logic [7:0]    SCORE_TOP = 8'(SCORE_MAX);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WAIT,
    S_STEP,
    S_DEAD
  } fsm_t;

  fsm_t          fsm_q, fsm_d;
  logic [CW-1:0] tick_q, tick_d;
  logic [DW-1:0] dead_q, dead_d;
  logic [1:0]    dir_q, dir_d;
  logic [1:0]    pend_q, pend_d;
  logic [7:0]    score_q, score_d;
  logic          step_q, step_d;
  logic          blank_q, blank_d;
  logic [3:0]    sync_1, sync_2;

  logic          code_valid;
  logic [1:0]    code;
  logic          accept;
  logic [1:0]    pend_arb;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_1 <= 4'd0;
      sync_2 <= 4'd0;
    end else begin
      sync_1 <= switch;
      sync_2 <= sync_1;
    end
  end

  always_comb begin
    code_valid = 1'b1;
    code       = 2'd3;
    case (sync_2)
      4'b1000: code = 2'd0;
      4'b0100: code = 2'd1;
      4'b0010: code = 2'd2;
      4'b0001: code = 2'd3;
      default: code_valid = 1'b0;
    endcase
  end

  // Headings are encoded so that the reverse of a direction differs only in
  // bit 0; a press that would turn the snake back onto itself is dropped.
  always_comb begin
    accept   = code_valid && (code != (dir_q ^ 2'd1)) &&
               ((fsm_q == S_IDLE) || (fsm_q == S_WAIT) || (fsm_q == S_STEP));
    pend_arb = accept ? code : pend_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fsm_q   <= S_INIT;
      tick_q  <= '0;
      dead_q  <= '0;
      dir_q   <= 2'd3;
      pend_q  <= 2'd3;
      score_q <= 8'd0;
      step_q  <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      tick_q  <= tick_d;
      dead_q  <= dead_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      score_q <= score_d;
      step_q  <= step_d;
      blank_q <= blank_d;
    end
  end

  // The tick timer is a down-counter loaded with TICK_DIV-1 and expiring at
  // zero, so every tick spans exactly TICK_DIV cycles of WAIT or DEAD.
  always_comb begin
    fsm_d   = fsm_q;
    tick_d  = tick_q;
    dead_d  = dead_q;
    dir_d   = dir_q;
    pend_d  = pend_arb;
    score_d = score_q;
    step_d  = 1'b0;
    blank_d = blank_q;

    case (fsm_q)
      S_INIT: begin
        dir_d  = 2'd3;
        pend_d = 2'd3;
        fsm_d  = S_IDLE;
      end

      S_IDLE: begin
        if (accept) begin
          score_d = 8'd0;
          tick_d  = TICK_LAST;
          fsm_d   = S_WAIT;
        end
      end

      S_WAIT: begin
        if (tick_q == '0) begin
          // Include a press accepted this very cycle so the committed
          // heading and pending never disagree across the step.
          dir_d  = pend_arb;
          step_d = 1'b1;
          tick_d = TICK_LAST;
          fsm_d  = S_STEP;
        end else begin
          tick_d = tick_q - CW'(1);
        end
      end

      S_STEP: begin
        if (step_done) begin
          tick_d = TICK_LAST;
          if (collide) begin
            dead_d = DEAD_LAST;
            fsm_d  = S_DEAD;
          end else begin
            if (eat && (score_q < SCORE_TOP)) begin
              score_d = score_q + 8'd1;
            end
            fsm_d = S_WAIT;
          end
        end
      end

      S_DEAD: begin
        pend_d = pend_q;
        if (tick_q == '0) begin
          tick_d = TICK_LAST;
          if (dead_q == '0) begin
            blank_d = 1'b0;
            fsm_d   = S_INIT;
          end else begin
            blank_d = ~blank_q;
            dead_d  = dead_q - DW'(1);
          end
        end else begin
          tick_d = tick_q - CW'(1);
        end
      end

      default: fsm_d = S_INIT;
    endcase
  end

  always_comb begin
    case (fsm_q)
      S_INIT:         state = 2'd0;
      S_IDLE:         state = 2'd1;
      S_WAIT, S_STEP: state = 2'd2;
      default:        state = 2'd3;
    endcase
  end

  assign step      = step_q;
  assign clear     = (fsm_q == S_INIT);
  assign direction = dir_q;
  assign score     = score_q;
  assign blank     = blank_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl with TICK_DIV=4, DEAD_TICKS=6. Expected step
// headings are queued by the stimulus thread; the monitor pops one whenever
// the DUT pulses step. All sampling happens on the falling clock edge.

module tb_snake_game_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] switch = 4'd0;
  logic       step_done = 1'b0;
  logic       collide = 1'b0;
  logic       eat = 1'b0;
  logic       step;
  logic       clear;
  logic [1:0] direction;
  logic [7:0] score;
  logic       blank;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  logic prev_step = 1'b0;

  always #5 clock = ~clock;

  snake_game_ctrl #(
    .TICK_DIV  (4),
    .DEAD_TICKS(6),
    .SCORE_MAX (255)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .switch   (switch),
    .step_done(step_done),
    .collide  (collide),
    .eat      (eat),
    .step     (step),
    .clear    (clear),
    .direction(direction),
    .score    (score),
    .blank    (blank),
    .state    (state)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every step pulse must be single-cycle and carry the queued heading.
  always @(negedge clock) begin
    int e;
    if (reset && step) begin
      check("step_single_cycle", prev_step, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_step_queue_depth", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("step_direction", direction, e);
      end
    end
    prev_step = step;
  end

  task automatic wait_step(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!step && n < 40);
    check("step_seen", step, 1);
  endtask

  task automatic wait_state(input int target, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (state != target && n < 20);
    check("state_reached", state, target);
  endtask

  task automatic send_done(input int lat, input logic c, input logic e);
    repeat (lat) @(posedge clock);
    #1;
    step_done = 1'b1;
    collide   = c;
    eat       = e;
    @(posedge clock);
    #1;
    step_done = 1'b0;
    collide   = 1'b0;
    eat       = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic prev;

    // Reset values and the INIT clear pulse
    repeat (3) @(negedge clock);
    check("reset_state", state, 0);
    check("reset_step", step, 0);
    check("reset_direction", direction, 3);
    check("reset_score", score, 0);
    check("reset_blank", blank, 0);
    reset = 1'b1;
    #1;
    check("init_clear", clear, 1);
    check("init_state", state, 0);
    @(negedge clock);
    check("idle_clear", clear, 0);
    check("idle_state", state, 1);

    // Left is the reverse of the initial heading, so it cannot start a game
    switch = 4'b0010;
    repeat (5) @(negedge clock);
    check("left_ignored_state", state, 1);
    switch = 4'b1000;
    wait_state(2, n);
    check("up_start_latency", n, 3);
    check("start_score", score, 0);
    switch = 4'b0000;
    exp_q.push_back(0);
    wait_step(n);
    check("first_step_latency", n, 4);
    check("step_in_run_state", state, 2);

    // Heading up: down is rejected
    switch = 4'b0100;
    repeat (4) @(negedge clock);
    switch = 4'b0000;
    exp_q.push_back(0);
    send_done(3, 1'b0, 1'b0);
    @(negedge clock);
    check("done_to_wait", state, 2);
    wait_step(n);
    check("step_after_done_a", n, 4);

    // Heading up: left is accepted
    switch = 4'b0010;
    repeat (4) @(negedge clock);
    switch = 4'b0000;
    exp_q.push_back(2);
    send_done(3, 1'b0, 1'b0);
    @(negedge clock);
    wait_step(n);
    check("step_after_done_b", n, 4);

    // Heading left: up then down, the last accepted press wins
    switch = 4'b1000;
    repeat (4) @(negedge clock);
    switch = 4'b0100;
    repeat (4) @(negedge clock);
    switch = 4'b0000;
    exp_q.push_back(1);
    send_done(2, 1'b0, 1'b0);
    @(negedge clock);
    wait_step(n);
    check("step_after_done_c", n, 4);

    // Eating: one increment per done, saturating at 255
    for (int i = 1; i <= 300; i++) begin
      exp_q.push_back(1);
      send_done(1, 1'b0, 1'b1);
      @(negedge clock);
      check("eat_score", score, (i > 255) ? 255 : i);
      if (i == 1) begin
        @(posedge clock);
        #1;
        step_done = 1'b1;
        eat       = 1'b1;
        @(posedge clock);
        #1;
        step_done = 1'b0;
        eat       = 1'b0;
        @(negedge clock);
        check("wait_done_ignored_score", score, 1);
        check("wait_done_ignored_state", state, 2);
      end
      wait_step(n);
    end

    // Collision with eat set: DEAD, score unchanged, six blink ticks
    send_done(2, 1'b1, 1'b1);
    @(negedge clock);
    check("dead_state", state, 3);
    check("dead_score", score, 255);
    check("dead_blank_start", blank, 0);
    prev = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      n = 0;
      do begin
        @(negedge clock);
        n++;
      end while (blank == prev && n < 20);
      check("blink_period", n, 4);
      prev = blank;
      if (i < 6) check("dead_hold_state", state, 3);
      if (i == 2) switch = 4'b1000;
      if (i == 4) switch = 4'b0000;
    end
    check("blink_final", blank, 0);
    check("restart_clear", clear, 1);
    check("restart_init_state", state, 0);
    @(negedge clock);
    check("restart_idle_state", state, 1);
    check("score_held_in_idle", score, 255);

    // New game: score cleared at start
    switch = 4'b1000;
    wait_state(2, n);
    check("restart_latency", n, 3);
    check("score_cleared_on_start", score, 0);
    switch = 4'b0000;
    exp_q.push_back(0);
    wait_step(n);
    check("restart_step_latency", n, 4);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(0);
      send_done(1, 1'b0, 1'b1);
      wait_step(n);
    end
    check("score_before_reset", score, 2);

    // Reset while STEP awaits done, with a done pending through release
    @(negedge clock);
    check("pre_reset_state", state, 2);
    reset     = 1'b0;
    step_done = 1'b1;
    eat       = 1'b1;
    #1;
    check("midreset_state", state, 0);
    check("midreset_step", step, 0);
    check("midreset_direction", direction, 3);
    check("midreset_score", score, 0);
    check("midreset_blank", blank, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    check("midreset_clear", clear, 1);
    @(negedge clock);
    check("post_reset_idle", state, 1);
    check("post_reset_clear_low", clear, 0);
    repeat (2) @(negedge clock);
    step_done = 1'b0;
    eat       = 1'b0;
    @(negedge clock);
    check("late_done_score", score, 0);
    check("late_done_state", state, 1);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
